// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module  : button_conditioner_pkg
// Brief   : Shared constants for the button conditioner: clicker action codes,
//           default timing parameters and btnC classifier state encodings.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef BUTTON_CONDITIONER_DEFS
`define BUTTON_CONDITIONER_DEFS
// Action codes understood by the downstream clicker.
`define OP_BtnC    3'b001
`define OP_DblBtnC 3'b010
`define OP_U       3'b100
`define OP_R       3'b101
`define OP_D       3'b110
`define OP_L       3'b111
`endif

package button_conditioner_pkg;

  // 5 ms debounce and 250 ms double-click window at 100 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_DBL_WINDOW      = 25000000;

  // btnC classifier states.
  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_WAIT = 1'b1;

  // Index of each button inside the packed raw/press vectors.
  localparam int c_IDX_C = 0;
  localparam int c_IDX_U = 1;
  localparam int c_IDX_R = 2;
  localparam int c_IDX_D = 3;
  localparam int c_IDX_L = 4;
  localparam int c_NUM_BTN = 5;

endpackage
`default_nettype wire

// File: rtl/button_conditioner_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module  : debounce_edge
// Brief   : Two-flop synchroniser, counter debouncer and registered one-cycle
//           pulse on every debounced 0->1 transition of one raw button.
// Revision: 1.0 - initial release
// ============================================================================
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = button_conditioner_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             st_q;
  logic             st_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    st_d    = st_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != st_q) begin
      if (cnt_q == c_CNT_LAST) begin
        st_d    = sync2_q;
        press_d = sync2_q;   // only a rising flip produces a pulse
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, stable state, counter and press pulse registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign stable = st_q;
  assign press  = press_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : button_conditioner
// Brief   : Debounces the five board buttons into one-cycle press pulses and
//           optionally classifies btnC presses as single or double clicks.
// Revision: 1.0 - initial release
// ============================================================================
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DBL_WINDOW      = DEFAULT_DBL_WINDOW,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic clear,
  input  logic btnC,
  input  logic btnU,
  input  logic btnR,
  input  logic btnD,
  input  logic btnL,
  input  logic DbleClkSwitch,
  output logic outbtnC,
  output logic outdblbtnC,
  output logic outU,
  output logic outR,
  output logic outD,
  output logic outL,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_WIN_LAST = CNT_W'(DBL_WINDOW - 1);

  logic [c_NUM_BTN-1:0] w_raw;
  logic [c_NUM_BTN-1:0] w_press;
  logic [c_NUM_BTN-1:0] w_unused_stable;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W-1:0] win_d;
  logic             single_q;
  logic             single_d;
  logic             dbl_q;
  logic             dbl_d;
  logic             w_press_c;

  assign w_raw = {btnL, btnD, btnR, btnU, btnC};

  generate
    for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_btn
      debounce_edge #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk   (clk),
        .clear (clear),
        .raw   (w_raw[gi]),
        .stable(w_unused_stable[gi]),
        .press (w_press[gi])
      );
    end
  endgenerate

  assign w_press_c = w_press[c_IDX_C];

  // Classifier state, window counter and registered click outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= c_ST_IDLE;
      win_q    <= '0;
      single_q <= 1'b0;
      dbl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      single_q <= single_d;
      dbl_q    <= dbl_d;
    end
  end

  // Next state: the mode switch only matters when a new press arrives in IDLE.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_press_c && DbleClkSwitch) begin
          state_d = c_ST_WAIT;
          win_d   = '0;
        end
      end
      c_ST_WAIT: begin
        if (w_press_c || (win_q == c_WIN_LAST)) begin
          state_d = c_ST_IDLE;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      default: begin
        state_d = c_ST_IDLE;
        win_d   = '0;
      end
    endcase
  end

  // Click decode: a second press beats a coincident timeout.
  always_comb begin
    single_d = 1'b0;
    dbl_d    = 1'b0;
    case (state_q)
      c_ST_IDLE: single_d = w_press_c && !DbleClkSwitch;
      c_ST_WAIT: begin
        if (w_press_c) begin
          dbl_d = 1'b1;
        end else if (win_q == c_WIN_LAST) begin
          single_d = 1'b1;
        end
      end
      default: begin
        single_d = 1'b0;
        dbl_d    = 1'b0;
      end
    endcase
  end

  assign outbtnC    = single_q;
  assign outdblbtnC = dbl_q;
  assign outU       = w_press[c_IDX_U];
  assign outR       = w_press[c_IDX_R];
  assign outD       = w_press[c_IDX_D];
  assign outL       = w_press[c_IDX_L];
  assign busy       = (state_q == c_ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_conditioner
// Brief   : Self-checking bench: directed scenarios plus random bouncing
//           buttons, compared every cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int WIN = 20;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic btnC = 1'b0, btnU = 1'b0, btnR = 1'b0, btnD = 1'b0, btnL = 1'b0;
  logic DbleClkSwitch = 1'b0;
  logic outbtnC, outdblbtnC, outU, outR, outD, outL, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_single, cnt_dbl, cnt_u, cnt_r, cnt_d, cnt_l;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .DBL_WINDOW     (WIN),
    .CNT_W          (5)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .btnC         (btnC),
    .btnU         (btnU),
    .btnR         (btnR),
    .btnD         (btnD),
    .btnL         (btnL),
    .DbleClkSwitch(DbleClkSwitch),
    .outbtnC      (outbtnC),
    .outdblbtnC   (outdblbtnC),
    .outU         (outU),
    .outR         (outR),
    .outD         (outD),
    .outL         (outL),
    .busy         (busy)
  );

  // ---------------- behavioural reference model ----------------
  // A button's stable level flips once the last DEB synchronised samples all
  // disagree with it. btnC clicks are classified from the time a first press
  // was accepted: a press within WIN cycles is a double click.
  logic [4:0]     m_s1 = '0, m_s2 = '0, m_st = '0, m_press = '0;
  logic [DEB-1:0] m_hist [5];
  logic           m_single = 1'b0, m_dbl = 1'b0, m_pend = 1'b0;
  int             m_cyc = 0, m_entry = 0;

  initial for (int b = 0; b < 5; b++) m_hist[b] = '0;

  always @(posedge clk) begin
    logic [4:0] raw;
    logic       s;
    raw = {btnL, btnD, btnR, btnU, btnC};
    if (clear) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_press = '0;
      for (int b = 0; b < 5; b++) m_hist[b] = '0;
      m_single = 1'b0; m_dbl = 1'b0; m_pend = 1'b0;
    end else begin
      m_single = 1'b0;
      m_dbl    = 1'b0;
      if (m_pend) begin
        if (m_press[0]) begin
          m_dbl = 1'b1; m_pend = 1'b0;
        end else if (m_cyc - m_entry == WIN) begin
          m_single = 1'b1; m_pend = 1'b0;
        end
      end else if (m_press[0]) begin
        if (DbleClkSwitch) begin
          m_pend = 1'b1; m_entry = m_cyc;
        end else begin
          m_single = 1'b1;
        end
      end
      for (int b = 0; b < 5; b++) begin
        s        = m_s2[b];
        m_s2[b]  = m_s1[b];
        m_s1[b]  = raw[b];
        m_hist[b] = {m_hist[b][DEB-2:0], s};
        if (m_hist[b] == {DEB{~m_st[b]}}) begin
          m_st[b]    = ~m_st[b];
          m_press[b] = m_st[b];
        end else begin
          m_press[b] = 1'b0;
        end
      end
    end
    m_cyc++;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // One cycle: compare every output with the model away from the edge.
  task automatic tick();
    @(negedge clk);
    chk("outbtnC",    32'(outbtnC),    32'(m_single));
    chk("outdblbtnC", 32'(outdblbtnC), 32'(m_dbl));
    chk("outU",       32'(outU),       32'(m_press[1]));
    chk("outR",       32'(outR),       32'(m_press[2]));
    chk("outD",       32'(outD),       32'(m_press[3]));
    chk("outL",       32'(outL),       32'(m_press[4]));
    chk("busy",       32'(busy),       32'(m_pend));
    cnt_single += int'(outbtnC);
    cnt_dbl    += int'(outdblbtnC);
    cnt_u += int'(outU); cnt_r += int'(outR);
    cnt_d += int'(outD); cnt_l += int'(outL);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_counts();
    cnt_single = 0; cnt_dbl = 0; cnt_u = 0; cnt_r = 0; cnt_d = 0; cnt_l = 0;
  endtask

  task automatic settle();
    {btnC, btnU, btnR, btnD, btnL} = '0;
    ticks(30);
    zero_counts();
  endtask

  // Hold btnC high until the classifier reports busy, then release it.
  task automatic press_until_busy(input string tag);
    int k;
    btnC = 1'b1;
    k = 0;
    while (!busy && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 32'(busy), 32'd1);
    btnC = 1'b0;
  endtask

  // Two btnC pulses of 6 cycles whose rising edges are 'gap' cycles apart.
  task automatic two_presses(input int gap);
    btnC = 1'b1; ticks(6);
    btnC = 1'b0; ticks(gap - 6);
    btnC = 1'b1; ticks(6);
    btnC = 1'b0;
  endtask

  int hold [5];

  initial begin
    zero_counts();
    // Reset with all buttons held high.
    {btnC, btnU, btnR, btnD, btnL} = '1;
    clear = 1'b1;
    ticks(3);
    chk("rst_clicks", 32'(cnt_single + cnt_dbl + cnt_u + cnt_r + cnt_d + cnt_l), 32'd0);
    clear = 1'b0;
    ticks(12);
    chk("rst_u", 32'(cnt_u), 32'd1);
    chk("rst_r", 32'(cnt_r), 32'd1);
    chk("rst_d", 32'(cnt_d), 32'd1);
    chk("rst_l", 32'(cnt_l), 32'd1);
    chk("rst_c", 32'(cnt_single), 32'd1);
    settle();

    // Bounce on btnU.
    for (int i = 0; i < 12; i++) begin
      btnU = ((i / 2) % 2 == 0);
      tick();
    end
    btnU = 1'b1; ticks(10);
    btnU = 1'b0; ticks(10);
    chk("bounce_u", 32'(cnt_u), 32'd1);
    chk("bounce_others", 32'(cnt_r + cnt_d + cnt_l), 32'd0);
    settle();

    // Single click with classification enabled.
    DbleClkSwitch = 1'b1;
    btnC = 1'b1; ticks(8);
    btnC = 1'b0; ticks(40);
    chk("single_c", 32'(cnt_single), 32'd1);
    chk("single_dbl", 32'(cnt_dbl), 32'd0);
    settle();

    // Double click, edges 12 apart.
    two_presses(12); ticks(40);
    chk("dbl12_dbl", 32'(cnt_dbl), 32'd1);
    chk("dbl12_single", 32'(cnt_single), 32'd0);
    settle();

    // Edges 20 apart: second press coincides with the timeout -> double.
    two_presses(20); ticks(40);
    chk("dbl20_dbl", 32'(cnt_dbl), 32'd1);
    chk("dbl20_single", 32'(cnt_single), 32'd0);
    settle();

    // Edges 21 apart: timeout single, then a fresh WAIT that also times out.
    two_presses(21); ticks(60);
    chk("gap21_single", 32'(cnt_single), 32'd2);
    chk("gap21_dbl", 32'(cnt_dbl), 32'd0);
    settle();

    // Mode switch while WAIT is pending.
    press_until_busy("mode_busy");
    ticks(3);
    DbleClkSwitch = 1'b0;
    ticks(25);
    btnC = 1'b1; ticks(6);
    btnC = 1'b0; ticks(15);
    chk("mode_single", 32'(cnt_single), 32'd2);
    chk("mode_dbl", 32'(cnt_dbl), 32'd0);
    settle();

    // Reset in the middle of WAIT.
    DbleClkSwitch = 1'b1;
    press_until_busy("rstw_busy");
    ticks(5);
    clear = 1'b1; tick();
    chk("rstw_busy_low", 32'(busy), 32'd0);
    clear = 1'b0; ticks(30);
    chk("rstw_clicks", 32'(cnt_single + cnt_dbl), 32'd0);
    settle();

    // Random bouncing buttons, mode changes and occasional resets.
    for (int b = 0; b < 5; b++) hold[b] = 1;
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] v;
      v = {btnL, btnD, btnR, btnU, btnC};
      for (int b = 0; b < 5; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          v[b] = ~v[b];
          hold[b] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 30));
        end
      end
      {btnL, btnD, btnR, btnU, btnC} = v;
      if ($urandom_range(0, 199) == 0) DbleClkSwitch = ~DbleClkSwitch;
      clear = ($urandom_range(0, 499) == 0);
      tick();
    end
    clear = 1'b0;
    ticks(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
